// File: rtl/plights_pkg.sv
// Shared types and constants for the plights pedestrian-crossing core:
// state encoding, default phase durations and width helpers.
package plights_pkg;

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED    = 3'd2,
    PED_GO     = 3'd3,
    PED_BLINK  = 3'd4,
    CAR_REDYEL = 3'd5
  } state_t;

  localparam int DEF_TICK_DIV    = 5000;
  localparam int DEF_T_GREEN_MIN = 8;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_T_PED       = 6;
  localparam int DEF_T_BLINK     = 4;
  localparam int DEF_T_REDYEL    = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Counters that only ever hold 0 still need a one-bit register.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/plights_tick.sv
// Tick prescaler: counts 0..TICK_DIV-1 and flags the last count for one
// clk_in cycle, giving the sequencer its phase-timing clock enable.
module plights_tick
  import plights_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick
);

  localparam int CW = width_of(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // With TICK_DIV=1 the count is permanently at LAST, so reset must mask it.
  assign tick = (cnt_reg == LAST) && !rst_in;

endmodule

// File: rtl/plights_sequencer.sv
// Pedestrian-crossing sequencer: phase FSM with a tick-driven countdown timer,
// latched button request and Moore lamp decode for the car and pedestrian heads.
module plights_sequencer
  import plights_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_PED       = DEF_T_PED,
  parameter int T_BLINK     = DEF_T_BLINK,
  parameter int T_REDYEL    = DEF_T_REDYEL
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic car_red,
  output logic car_yellow,
  output logic car_green,
  output logic ped_red,
  output logic ped_green,
  output logic wait_out,
  output logic tick_out
);

  localparam int T_MAX = max2(max2(max2(T_GREEN_MIN, T_YELLOW), max2(T_ALLRED, T_PED)),
                              max2(T_BLINK, T_REDYEL));
  localparam int TW = width_of(T_MAX);
  // Timer LSB value seen during the first (lit) tick of the blink phase.
  localparam logic BLINK_ON_LSB = 1'((T_BLINK - 1) % 2);

  logic          tick;
  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          req_reg, req_next;
  logic          btn_prev_reg;
  logic          phase_done;
  logic          btn_rise;
  logic          entering_ped_go;

  plights_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .tick  (tick)
  );

  function automatic logic [TW-1:0] load_value(input state_t s);
    case (s)
      CAR_YELLOW: return TW'(T_YELLOW - 1);
      ALL_RED:    return TW'(T_ALLRED - 1);
      PED_GO:     return TW'(T_PED - 1);
      PED_BLINK:  return TW'(T_BLINK - 1);
      CAR_REDYEL: return TW'(T_REDYEL - 1);
      default:    return TW'(T_GREEN_MIN - 1);
    endcase
  endfunction

  always_comb begin
    phase_done = tick && (timer_reg == '0);
    state_next = state_reg;
    if (phase_done) begin
      case (state_reg)
        CAR_GREEN:  if (req_reg) state_next = CAR_YELLOW;
        CAR_YELLOW: state_next = ALL_RED;
        ALL_RED:    state_next = PED_GO;
        PED_GO:     state_next = PED_BLINK;
        PED_BLINK:  state_next = CAR_REDYEL;
        CAR_REDYEL: state_next = CAR_GREEN;
        default:    state_next = CAR_GREEN;
      endcase
    end
  end

  // Transitions only happen on ticks, so loading D-1 keeps every phase tick-aligned.
  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg) begin
      timer_next = load_value(state_next);
    end else if (tick && (timer_reg != '0)) begin
      timer_next = timer_reg - TW'(1);
    end
  end

  always_comb begin
    btn_rise        = btn_in && !btn_prev_reg;
    entering_ped_go = (state_next == PED_GO) && (state_reg != PED_GO);
    req_next        = req_reg;
    if (entering_ped_go) begin
      req_next = 1'b0;
    end else if (btn_rise) begin
      req_next = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= CAR_GREEN;
      timer_reg    <= TW'(T_GREEN_MIN - 1);
      req_reg      <= 1'b0;
      btn_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      req_reg      <= req_next;
      btn_prev_reg <= btn_in;
    end
  end

  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b1;
    ped_green  = 1'b0;
    case (state_reg)
      CAR_GREEN:  car_green = 1'b1;
      CAR_YELLOW: car_yellow = 1'b1;
      ALL_RED:    car_red = 1'b1;
      PED_GO: begin
        car_red   = 1'b1;
        ped_red   = 1'b0;
        ped_green = 1'b1;
      end
      PED_BLINK: begin
        car_red   = 1'b1;
        ped_red   = 1'b0;
        ped_green = (timer_reg[0] == BLINK_ON_LSB);
      end
      CAR_REDYEL: begin
        car_red    = 1'b1;
        car_yellow = 1'b1;
      end
      default:    car_green = 1'b1;
    endcase
  end

  assign wait_out = req_reg;
  assign tick_out = tick;

endmodule
